// File: rtl/motoro3_hall_decoder.sv
`timescale 1ns/1ps
// Hall decoder: synchronizes and debounces three Hall lines into commutation steps 1..6 plus direction, period, rounds, stall and fault.
// Latency: 2 + DEBOUNCE falling edges from a clean Hall change to hStepPulse. No backpressure; all state on falling clk edges.
module motoro3_hall_decoder #(
    parameter int unsigned DEBOUNCE    = 4,
    parameter logic [24:0] STALL_LIMIT = 25'd10_000_000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        enable,
    input  logic        hallA,
    input  logic        hallB,
    input  logic        hallC,
    output logic [3:0]  hStep,
    output logic        hDir,
    output logic        hStepPulse,
    output logic [24:0] hPeriod,
    output logic        hPeriodValid,
    output logic        hStall,
    output logic        hFault,
    output logic [15:0] hRoundCnt
);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, acc_q, acc_d;
    logic [3:0]  deb_q, deb_d, step_q, step_d;
    logic        dir_q, dir_d, pulse_q, pulse_d, pvalid_q, pvalid_d;
    logic        stall_q, stall_d, fault_q, fault_d;
    logic [24:0] period_q, period_d, cnt_q, cnt_d;
    logic [15:0] round_q, round_d;

    logic [3:0]  deb_next, step_new, step_fwd, step_rev;
    logic        accept, legal_acc, at_limit;

    function automatic logic [3:0] code_to_step(input logic [2:0] code);
        case (code)
            3'b101:  code_to_step = 4'd1;
            3'b100:  code_to_step = 4'd2;
            3'b110:  code_to_step = 4'd3;
            3'b010:  code_to_step = 4'd4;
            3'b011:  code_to_step = 4'd5;
            3'b001:  code_to_step = 4'd6;
            default: code_to_step = 4'd0;
        endcase
    endfunction

    always_comb begin
        sync1_d   = {hallA, hallB, hallC};
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        acc_d     = acc_q;
        step_d    = step_q;
        dir_d     = dir_q;
        pulse_d   = 1'b0;
        period_d  = period_q;
        pvalid_d  = pvalid_q;
        stall_d   = stall_q;
        fault_d   = fault_q;
        round_d   = round_q;
        legal_acc = 1'b0;

        step_new = code_to_step(sync2_q);
        step_fwd = (step_q == 4'd6) ? 4'd1 : step_q + 4'd1;
        step_rev = (step_q == 4'd1) ? 4'd6 : step_q - 4'd1;
        at_limit = (cnt_q == STALL_LIMIT);
        cnt_d    = at_limit ? cnt_q : cnt_q + 25'd1;

        // Stability run of a candidate code; a sticky fault freezes acceptance.
        if (fault_q || (sync2_q == acc_q)) begin
            deb_next = 4'd0;
        end else if (sync2_q != prev_q) begin
            deb_next = 4'd1;
        end else if (deb_q != 4'hF) begin
            deb_next = deb_q + 4'd1;
        end else begin
            deb_next = deb_q;
        end
        accept = (deb_next == DEB);
        deb_d  = accept ? 4'd0 : deb_next;

        if (accept) begin
            acc_d = sync2_q;
            if (step_new == 4'd0) begin
                fault_d = 1'b1;
                step_d  = 4'd7;
            end else begin
                pulse_d   = 1'b1;
                legal_acc = 1'b1;
                if (step_q == 4'd0) begin
                    step_d  = step_new;
                    cnt_d   = 25'd1;
                    stall_d = 1'b0;
                end else if (step_new == step_fwd || step_new == step_rev) begin
                    dir_d    = (step_new == step_fwd);
                    if (step_q == 4'd6 && step_new == 4'd1) round_d = round_q + 16'd1;
                    if (step_q == 4'd1 && step_new == 4'd6) round_d = round_q - 16'd1;
                    step_d   = step_new;
                    period_d = cnt_q;
                    pvalid_d = 1'b1;
                    cnt_d    = 25'd1;
                    stall_d  = 1'b0;
                end else begin
                    fault_d  = 1'b1;
                    step_d   = 4'd7;
                    pvalid_d = 1'b0;
                end
            end
        end

        // A step landing on the saturation cycle wins over the stall.
        if (at_limit && !legal_acc) begin
            stall_d  = 1'b1;
            pvalid_d = 1'b0;
            if (!fault_d) step_d = 4'd0;
        end

        if (!enable) begin
            acc_d    = 3'd0;
            deb_d    = 4'd0;
            step_d   = 4'd0;
            dir_d    = 1'b1;
            pulse_d  = 1'b0;
            period_d = 25'd0;
            pvalid_d = 1'b0;
            stall_d  = 1'b0;
            fault_d  = 1'b0;
            round_d  = 16'd0;
            cnt_d    = 25'd0;
        end
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q  <= 3'd0;
            sync2_q  <= 3'd0;
            prev_q   <= 3'd0;
            acc_q    <= 3'd0;
            deb_q    <= 4'd0;
            step_q   <= 4'd0;
            dir_q    <= 1'b1;
            pulse_q  <= 1'b0;
            period_q <= 25'd0;
            pvalid_q <= 1'b0;
            stall_q  <= 1'b0;
            fault_q  <= 1'b0;
            round_q  <= 16'd0;
            cnt_q    <= 25'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            deb_q    <= deb_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            pulse_q  <= pulse_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
            stall_q  <= stall_d;
            fault_q  <= fault_d;
            round_q  <= round_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hStep        = step_q;
    assign hDir         = dir_q;
    assign hStepPulse   = pulse_q;
    assign hPeriod      = period_q;
    assign hPeriodValid = pvalid_q;
    assign hStall       = stall_q;
    assign hFault       = fault_q;
    assign hRoundCnt    = round_q;

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
`timescale 1ns/1ps
// Directed bench for motoro3_hall_decoder: a reference model built from the decoding rules
// is compared with the DUT every rising edge, plus literal checkpoints at key scenario points.
module tb_motoro3_hall_decoder;
    localparam int DEB  = 4;
    localparam int LIM  = 3000;
    localparam int HOLD = 1667;

    logic        clk, nRst, enable, hallA, hallB, hallC;
    logic [3:0]  hStep;
    logic        hDir, hStepPulse, hPeriodValid, hStall, hFault;
    logic [24:0] hPeriod;
    logic [15:0] hRoundCnt;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int step_log[$];

    logic [3:0]  m_step;
    logic        m_dir, m_pulse, m_pvalid, m_stall, m_fault;
    logic [24:0] m_period;
    logic [15:0] m_round;
    int          m_cnt;
    logic [2:0]  m_acc;
    logic [2:0]  hq[$];
    logic [2:0]  dq[$];
    logic [2:0]  seq_codes[6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    motoro3_hall_decoder #(.DEBOUNCE(DEB), .STALL_LIMIT(25'(LIM))) dut (
        .clk(clk), .nRst(nRst), .enable(enable),
        .hallA(hallA), .hallB(hallB), .hallC(hallC),
        .hStep(hStep), .hDir(hDir), .hStepPulse(hStepPulse),
        .hPeriod(hPeriod), .hPeriodValid(hPeriodValid),
        .hStall(hStall), .hFault(hFault), .hRoundCnt(hRoundCnt)
    );

    initial begin
        clk = 1'b1;
        forever #50 clk = ~clk;
    end

    function automatic int step_of(input logic [2:0] code);
        for (int i = 0; i < 6; i++) if (seq_codes[i] == code) return i + 1;
        return 0;
    endfunction

    task automatic model_clear();
        m_step = 4'd0; m_dir = 1'b1; m_pulse = 1'b0; m_period = 25'd0;
        m_pvalid = 1'b0; m_stall = 1'b0; m_fault = 1'b0; m_round = 16'd0;
        m_cnt = 0; m_acc = 3'd0;
        dq.delete();
    endtask

    task automatic model_reset();
        model_clear();
        hq.delete();
        hq.push_back(3'd0);
        hq.push_back(3'd0);
    endtask

    // One falling edge: the decision sees the Hall value sampled two edges earlier.
    task automatic model_step();
        logic [2:0] c;
        int run, s, p, d, old;
        bit accept, legal_acc, reload;
        c = hq.pop_front();
        hq.push_back({hallA, hallB, hallC});
        if (!enable) begin
            model_clear();
        end else begin
            m_pulse = 1'b0; accept = 0; legal_acc = 0; reload = 0; old = m_cnt;
            if (!m_fault) begin
                dq.push_back(c);
                if (dq.size() > 16) void'(dq.pop_front());
                run = 0;
                for (int i = dq.size() - 1; i >= 0; i--) begin
                    if (dq[i] != c) break;
                    run++;
                end
                accept = (c != m_acc) && (run >= DEB);
            end
            if (accept) begin
                dq.delete();
                m_acc = c;
                s = step_of(c);
                p = int'(m_step);
                if (s == 0) begin
                    m_fault = 1'b1; m_step = 4'd7;
                end else begin
                    m_pulse = 1'b1; legal_acc = 1;
                    d = (s - p + 6) % 6;
                    if (p == 0) begin
                        m_step = 4'(s); m_stall = 1'b0; reload = 1;
                    end else if (d == 1 || d == 5) begin
                        m_dir = (d == 1);
                        if (p == 6 && s == 1) m_round = m_round + 16'd1;
                        if (p == 1 && s == 6) m_round = m_round - 16'd1;
                        m_step = 4'(s); m_period = 25'(old); m_pvalid = 1'b1;
                        m_stall = 1'b0; reload = 1;
                    end else begin
                        m_fault = 1'b1; m_step = 4'd7; m_pvalid = 1'b0;
                    end
                end
            end
            if (old == LIM && !legal_acc) begin
                m_stall = 1'b1; m_pvalid = 1'b0;
                if (!m_fault) m_step = 4'd0;
            end
            m_cnt = reload ? 1 : ((old >= LIM) ? LIM : old + 1);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk or negedge nRst);
            if (!nRst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (nRst === 1'b1) begin
                n_tests++;
                if ({hStep, hDir, hStepPulse, hPeriod, hPeriodValid, hStall, hFault, hRoundCnt} !==
                    {m_step, m_dir, m_pulse, m_period, m_pvalid, m_stall, m_fault, m_round}) begin
                    n_fail++;
                    $display("FAIL model_cycle t=%0t dut step=%0d dir=%b pulse=%b period=%0d pv=%b stall=%b fault=%b round=%h | model step=%0d dir=%b pulse=%b period=%0d pv=%b stall=%b fault=%b round=%h",
                             $time, hStep, hDir, hStepPulse, hPeriod, hPeriodValid, hStall, hFault, hRoundCnt,
                             m_step, m_dir, m_pulse, m_period, m_pvalid, m_stall, m_fault, m_round);
                end
                if (hStepPulse === 1'b1) begin
                    pulse_cnt++;
                    step_log.push_back(int'(hStep));
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_hall(input logic [2:0] c);
        {hallA, hallB, hallC} = c;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] fwd_codes[6];
        int p0;
        fwd_codes = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        nRst = 1'b0; enable = 1'b0;
        set_hall(3'b000);
        wait_cyc(3);
        check("rst_step", hStep, 0);
        check("rst_dir", hDir, 1);
        check("rst_period", hPeriod, 0);
        check("rst_flags", {hStepPulse, hPeriodValid, hStall, hFault}, 0);
        check("rst_round", hRoundCnt, 0);

        // First step: accepted on the sixth falling edge after release
        set_hall(3'b101); enable = 1'b1; nRst = 1'b1;
        wait_cyc(5);
        check("first_before", hStep, 0);
        wait_cyc(1);
        check("first_step", hStep, 1);
        check("first_pulse", hStepPulse, 1);
        wait_cyc(1);
        check("first_pulse_once", pulse_cnt, 1);
        check("first_pvalid", hPeriodValid, 0);
        check("first_dir", hDir, 1);

        // Full forward electrical round
        wait_cyc(10);
        step_log.delete();
        for (int i = 0; i < 6; i++) begin
            set_hall(fwd_codes[i]);
            wait_cyc(HOLD);
        end
        check("fwd_step", hStep, 1);
        check("fwd_dir", hDir, 1);
        check("fwd_period", hPeriod, HOLD);
        check("fwd_pvalid", hPeriodValid, 1);
        check("fwd_round", hRoundCnt, 1);
        check("fwd_npulse", step_log.size(), 6);
        for (int i = 0; i < 6 && i < step_log.size(); i++)
            check("fwd_seq", step_log[i], (i + 1) % 6 + 1);

        // Reverse from a fresh enable
        enable = 1'b0;
        wait_cyc(2);
        check("dis_round", hRoundCnt, 0);
        enable = 1'b1;
        wait_cyc(HOLD);
        check("rev_first", hStep, 1);
        set_hall(3'b001);
        wait_cyc(HOLD);
        set_hall(3'b011);
        wait_cyc(HOLD);
        check("rev_dir", hDir, 0);
        check("rev_step", hStep, 5);
        check("rev_round", hRoundCnt, 16'hFFFF);
        check("rev_period", hPeriod, HOLD);

        // Glitches: 3 cycles rejected, 4 cycles accepted
        enable = 1'b0;
        wait_cyc(2);
        set_hall(3'b101); enable = 1'b1;
        wait_cyc(20);
        p0 = pulse_cnt;
        set_hall(3'b100); wait_cyc(3);
        set_hall(3'b101); wait_cyc(20);
        check("glitch3_pulses", pulse_cnt, p0);
        check("glitch3_step", hStep, 1);
        set_hall(3'b100); wait_cyc(4);
        set_hall(3'b101); wait_cyc(20);
        check("glitch4_pulses", pulse_cnt, p0 + 2);
        check("glitch4_step", hStep, 1);
        check("glitch4_dir", hDir, 0);

        // Skip fault, sticky until enable falls
        set_hall(3'b100); wait_cyc(20);
        set_hall(3'b010); wait_cyc(20);
        check("skip_fault", hFault, 1);
        check("skip_step", hStep, 7);
        set_hall(3'b011); wait_cyc(20);
        check("skip_sticky", hStep, 7);
        enable = 1'b0;
        wait_cyc(1);
        check("fault_cleared", hFault, 0);
        enable = 1'b1;
        wait_cyc(20);
        check("reenable_step", hStep, 5);

        // Illegal code
        p0 = pulse_cnt;
        set_hall(3'b111); wait_cyc(10);
        check("ill_fault", hFault, 1);
        check("ill_step", hStep, 7);
        check("ill_nopulse", pulse_cnt, p0);

        // Stall, then first-step recovery
        enable = 1'b0; wait_cyc(2);
        set_hall(3'b101); enable = 1'b1; wait_cyc(20);
        set_hall(3'b100); wait_cyc(20);
        check("pre_stall_pvalid", hPeriodValid, 1);
        wait_cyc(LIM + 20);
        check("stall_flag", hStall, 1);
        check("stall_pvalid", hPeriodValid, 0);
        check("stall_step", hStep, 0);
        set_hall(3'b110); wait_cyc(20);
        check("unstall_flag", hStall, 0);
        check("unstall_step", hStep, 3);
        check("unstall_pvalid", hPeriodValid, 0);

        // Step exactly on saturation: step wins
        wait_cyc(LIM - 20);
        set_hall(3'b010); wait_cyc(20);
        check("sat_step", hStep, 4);
        check("sat_stall", hStall, 0);
        check("sat_period", hPeriod, LIM);
        check("sat_pvalid", hPeriodValid, 1);

        // One cycle past saturation: stall first, then first step
        wait_cyc(LIM - 20 + 1);
        set_hall(3'b011); wait_cyc(20);
        check("late_step", hStep, 5);
        check("late_pvalid", hPeriodValid, 0);
        check("late_period", hPeriod, LIM);

        // Async reset mid-debounce
        set_hall(3'b001); wait_cyc(3);
        nRst = 1'b0;
        #1;
        check("arst_step", hStep, 0);
        check("arst_dir", hDir, 1);
        check("arst_period", hPeriod, 0);
        check("arst_flags", {hStepPulse, hPeriodValid, hStall, hFault}, 0);
        check("arst_round", hRoundCnt, 0);
        wait_cyc(3);
        nRst = 1'b1;
        wait_cyc(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motoro3_hall_decoder.md
Name: motoro3_hall_decoder

Overview:
- Feedback-side counterpart of the six-step commutation sequencer.
- Samples the motor's three Hall sensor lines and decodes them into the same 1..6 step numbering the sequencer drives.
- Reports rotation direction, measured step period, electrical round count, and stall and fault status.
- Sits between the Hall input pins and speed/position control logic, on the 10 MHz system clock.

Parameters:
DEBOUNCE, 4, consecutive clk cycles a new Hall code must be stable before acceptance (1..15)
STALL_LIMIT, 25'd10_000_000, period counter saturation value in clk cycles (1 s at 10 MHz); reaching it flags stall

Ports:
clk  input  1  system clock, 10 MHz; all registers update on falling edge
nRst  input  1  asynchronous active-low reset
enable  input  1  decoder run; low clears all decoder state except synchronizers
hallA  input  1  Hall sensor A, asynchronous
hallB  input  1  Hall sensor B, asynchronous
hallC  input  1  Hall sensor C, asynchronous
hStep  output  4  decoded step: 0 idle/unknown, 1..6 valid, 7 fault
hDir  output  1  1 forward (ascending steps), 0 reverse; valid once two steps are accepted
hStepPulse  output  1  one-cycle strobe on each accepted step change
hPeriod  output  25  clk cycles between the last two accepted steps
hPeriodValid  output  1  hPeriod holds a genuine measurement
hStall  output  1  no accepted step for STALL_LIMIT cycles
hFault  output  1  sticky: illegal code or step skip seen
hRoundCnt  output  16  signed electrical-round counter, wraps modulo 2^16

Behaviour:
- Reset (nRst low, async): hStep=0, hDir=1, hStepPulse=0, hPeriod=0, hPeriodValid=0, hStall=0, hFault=0, hRoundCnt=0; period counter=0; debounce counter=0; synchronizers=0.
- Synchronize: each Hall line passes a 2-flop falling-edge synchronizer; code = {A,B,C} at sync output.
- Code map: 101→1, 100→2, 110→3, 010→4, 011→5, 001→6. 000 and 111 are illegal.
- Debounce: counter counts consecutive cycles the synced code equals its previous-cycle value and differs from the accepted code.
  - Any change restarts the count.
  - At DEBOUNCE the code is accepted.
  - Latency from first edge sampling a clean change to hStepPulse = 2 + DEBOUNCE falling edges.
  - Glitches shorter than DEBOUNCE cycles produce no event.
- On acceptance of a legal code S with previous step P:
  - P=0 (first step after enable/reset/stall): hStep=S, no direction or round update, hPeriodValid stays 0.
  - S=P+1, or P=6 with S=1: hDir=1. If P=6, S=1, hRoundCnt+1.
  - S=P−1, or P=1 with S=6: hDir=0. If P=1, S=6, hRoundCnt−1.
  - Any other S (skip of 2 or 3): hFault=1, hStep=7, hPeriodValid=0.
  - hStepPulse=1 for exactly one cycle on every accepted legal code, including the first.
- On acceptance of an illegal code: hFault=1, hStep=7, no hStepPulse.
- Fault is sticky. hStep stays 7 and further codes are ignored until enable falls.
- Period counter:
  - Increments each cycle while enable=1; saturates at STALL_LIMIT.
  - On each accepted legal step with P in 1..6: hPeriod←counter, hPeriodValid=1, counter←1.
  - On the first step: counter←1 only.
- Stall: when the counter reaches STALL_LIMIT, hStall=1, hPeriodValid=0, hStep=0 (the next step is treated as first).
  - hStall clears on the next accepted legal step.
- Simultaneous acceptance and STALL_LIMIT in the same cycle: acceptance wins, with the saturated count loaded into hPeriod.
- enable=0: all outputs and counters return to reset values on the next falling edge. Synchronizers keep running. A code present at enable rise is accepted after debounce as a first step.
- Counter widths: hPeriod/counter 25 bits, unsigned. hRoundCnt two's complement, wraps 0x7FFF→0x8000 and 0x0000−1→0xFFFF.

Test Plan:
- Reset then enable=1, Hall=101 held → after 2+4 falling edges, hStep=1, one hStepPulse, hPeriodValid=0, hDir=1.
- Forward sequence 101,100,110,010,011,001,101, each held 1667 cycles → hStep 1..6→1, hDir=1, hPeriod=1667, hPeriodValid=1, hRoundCnt=1.
- Reverse sequence 101,001,011 each held 1667 cycles → hDir=0, hStep 1→6→5, hRoundCnt=0xFFFF.
- 3-cycle glitch 101→100→101 → no hStepPulse, hStep unchanged. Then 100 jumping to 010 (skip) → hFault=1, hStep=7. enable low→high → hFault=0.
- Illegal code 111 held 10 cycles → hFault=1, hStep=7, no pulse.
- Hold code 10,000,000 cycles → hStall=1, hPeriodValid=0, hStep=0. Next legal code → hStall=0, first-step behaviour. Assert nRst mid-sequence → all outputs at reset values immediately.
